ball_motion_ctrl: RTL and testbench



---
 rtl/ball_pkg.sv | 23 ++
 rtl/ball_motion_ctrl_if.sv | 33 +++
 rtl/step_tick.sv | 38 +++
 rtl/ball_motion_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ball_motion_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ball_pkg.sv
// Shared ball/playfield definitions: FSM states, geometry defaults, direction encodings.
package ball_pkg;

   localparam int unsigned SCREEN_W  = 320;
   localparam int unsigned SCREEN_H  = 240;
   localparam int unsigned BALL_SIZE = 4;
   localparam int unsigned PADDLE_W  = 32;
   localparam int unsigned PADDLE_Y  = 224;

   localparam logic DIR_INC = 1'b1;
   localparam logic DIR_DEC = 1'b0;

   typedef enum logic [2:0] {
      StIdle,
      StServe,
      StMove,
      StStep,
      StCheck,
      StLost,
      StOver
   } state_e;

endpackage

// File: rtl/ball_motion_ctrl_if.sv
// Signal bundle between the game top / ball_pos and the ball motion sequencer.
interface ball_motion_ctrl_if;

   logic       start;
   logic       pause;
   logic       hit_x;
   logic       hit_y;
   logic [9:0] paddle_x;
   logic [9:0] ball_x;
   logic [9:0] ball_y;

   logic       move_en;
   logic       x_du;
   logic       y_du;
   logic       pos_clr_n;
   logic       paddle_hit;
   logic       ball_lost;
   logic       game_over;
   logic [2:0] lives;

   // Game side: drives requests and ball_pos read-back, observes sequencer outputs.
   modport master (
      output start, pause, hit_x, hit_y, paddle_x, ball_x, ball_y,
      input  move_en, x_du, y_du, pos_clr_n, paddle_hit, ball_lost, game_over, lives
   );

   // Sequencer side.
   modport slave (
      input  start, pause, hit_x, hit_y, paddle_x, ball_x, ball_y,
      output move_en, x_du, y_du, pos_clr_n, paddle_hit, ball_lost, game_over, lives
   );

endinterface

// File: rtl/step_tick.sv
// Step pacing counter: counts enabled cycles and flags the last one of each period.
module step_tick #(
   parameter int unsigned TickDiv = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int unsigned   CntW   = (TickDiv > 1) ? $clog2(TickDiv) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TickDiv - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Next count: clear wins, wrap at terminal count so a stray extra enable is harmless.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == CntMax);

endmodule

// File: rtl/ball_motion_ctrl.sv
// Ball motion sequencer: paces ball_pos steps, resolves wall/paddle/brick bounces, tracks lives.
module ball_motion_ctrl #(
   parameter int unsigned SCREEN_W  = ball_pkg::SCREEN_W,
   parameter int unsigned SCREEN_H  = ball_pkg::SCREEN_H,
   parameter int unsigned BALL_SIZE = ball_pkg::BALL_SIZE,
   parameter int unsigned PADDLE_W  = ball_pkg::PADDLE_W,
   parameter int unsigned PADDLE_Y  = ball_pkg::PADDLE_Y,
   parameter int unsigned TICK_DIV  = 250000,
   parameter int unsigned LIVES     = 3
) (
   input logic                clk,
   input logic                resetn,
   ball_motion_ctrl_if.slave  bus_io
);

   import ball_pkg::*;

   // All geometry compares are 11 bits so sums of 10-bit coordinates cannot wrap.
   localparam logic [10:0] LostY     = 11'(SCREEN_H - BALL_SIZE);
   localparam logic [10:0] RightX    = 11'(SCREEN_W - BALL_SIZE);
   localparam logic [10:0] BallSz    = 11'(BALL_SIZE);
   localparam logic [10:0] PadW      = 11'(PADDLE_W);
   localparam logic [10:0] PadY      = 11'(PADDLE_Y);
   localparam logic [2:0]  LivesInit = 3'(LIVES);

   state_e     state_q, state_d;
   logic       x_du_q, x_du_d;
   logic       y_du_q, y_du_d;
   logic       pend_x_q, pend_x_d;
   logic       pend_y_q, pend_y_d;
   logic       paddle_hit_q, paddle_hit_d;
   logic [2:0] lives_q, lives_d;

   logic        tick_tc, tick_en, tick_clr;
   logic [10:0] bx, by, px;
   logic        hit_x_any, hit_y_any, on_paddle;

   assign bx = {1'b0, bus_io.ball_x};
   assign by = {1'b0, bus_io.ball_y};
   assign px = {1'b0, bus_io.paddle_x};

   // A pulse arriving in CHECK itself is folded in so it is consumed by that CHECK.
   assign hit_x_any = pend_x_q | bus_io.hit_x;
   assign hit_y_any = pend_y_q | bus_io.hit_y;

   assign on_paddle = (y_du_q == DIR_INC) && ((by + BallSz) == PadY) &&
                      ((bx + BallSz) > px) && (bx < (px + PadW));

   assign tick_en  = (state_q == StMove) && !bus_io.pause;
   assign tick_clr = (state_q == StServe) || (state_q == StCheck);

   step_tick #(
      .TickDiv (TICK_DIV)
   ) u_step_tick (
      .clk_i  (clk),
      .rst_ni (resetn),
      .clr_i  (tick_clr),
      .en_i   (tick_en),
      .tc_o   (tick_tc)
   );

   // State and datapath registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= StIdle;
         x_du_q       <= DIR_INC;
         y_du_q       <= DIR_INC;
         pend_x_q     <= 1'b0;
         pend_y_q     <= 1'b0;
         paddle_hit_q <= 1'b0;
         lives_q      <= 3'd0;
      end else begin
         state_q      <= state_d;
         x_du_q       <= x_du_d;
         y_du_q       <= y_du_d;
         pend_x_q     <= pend_x_d;
         pend_y_q     <= pend_y_d;
         paddle_hit_q <= paddle_hit_d;
         lives_q      <= lives_d;
      end
   end

   // Next state, direction resolution, hit capture and lives bookkeeping.
   always_comb begin
      state_d      = state_q;
      x_du_d       = x_du_q;
      y_du_d       = y_du_q;
      pend_x_d     = pend_x_q;
      pend_y_d     = pend_y_q;
      paddle_hit_d = 1'b0;
      lives_d      = lives_q;

      if ((state_q == StMove) || (state_q == StStep)) begin
         pend_x_d = hit_x_any;
         pend_y_d = hit_y_any;
      end

      unique case (state_q)
         StIdle: begin
            if (bus_io.start) begin
               lives_d = LivesInit;
               state_d = StServe;
            end
         end
         StServe: begin
            x_du_d   = DIR_INC;
            y_du_d   = DIR_INC;
            pend_x_d = 1'b0;
            pend_y_d = 1'b0;
            state_d  = StMove;
         end
         StMove: begin
            if (!bus_io.pause && tick_tc) begin
               state_d = StStep;
            end
         end
         StStep: begin
            state_d = StCheck;
         end
         StCheck: begin
            pend_x_d = 1'b0;
            pend_y_d = 1'b0;
            if (by >= LostY) begin
               lives_d = lives_q - 3'd1;
               state_d = (lives_q == 3'd1) ? StOver : StLost;
            end else begin
               // Walls take priority over brick hits on the same axis.
               if (bx == 11'd0) begin
                  x_du_d = DIR_INC;
               end else if (bx >= RightX) begin
                  x_du_d = DIR_DEC;
               end else if (hit_x_any) begin
                  x_du_d = ~x_du_q;
               end

               if (by == 11'd0) begin
                  y_du_d = DIR_INC;
               end else if (on_paddle) begin
                  y_du_d       = DIR_DEC;
                  paddle_hit_d = 1'b1;
               end else if (hit_y_any) begin
                  y_du_d = ~y_du_q;
               end
               state_d = StMove;
            end
         end
         StLost: begin
            if (bus_io.start) begin
               state_d = StServe;
            end
         end
         StOver: begin
            if (bus_io.start) begin
               lives_d = LivesInit;
               state_d = StServe;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs: registered values or decoded from the current state only.
   always_comb begin
      bus_io.move_en    = (state_q == StStep);
      bus_io.pos_clr_n  = !((state_q == StIdle) || (state_q == StServe));
      bus_io.ball_lost  = (state_q == StLost);
      bus_io.game_over  = (state_q == StOver);
      bus_io.x_du       = x_du_q;
      bus_io.y_du       = y_du_q;
      bus_io.paddle_hit = paddle_hit_q;
      bus_io.lives      = lives_q;
   end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl with a behavioural ball_pos and an event scoreboard.
module tb_ball_motion_ctrl;

   localparam int TickDiv = 4;
   localparam int LivesP  = 2;

   localparam int KStep   = 0;
   localparam int KPaddle = 1;
   localparam int KLost   = 2;
   localparam int KOver   = 3;

   typedef struct {
      int kind;
      int cyc;
      int x;
      int y;
      int xdu;
      int ydu;
      int lives;
   } exp_t;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   ball_motion_ctrl_if bus ();

   ball_motion_ctrl #(
      .TICK_DIV (TickDiv),
      .LIVES    (LivesP)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   // Behavioural ball_pos with a bench-side position preload.
   logic [9:0] bx, by, ld_x, ld_y;
   logic       ld;

   always @(posedge clk) begin
      if (!bus.pos_clr_n) begin
         bx <= '0;
         by <= '0;
      end else if (ld) begin
         bx <= ld_x;
         by <= ld_y;
      end else if (bus.move_en) begin
         bx <= bus.x_du ? bx + 10'd1 : bx - 10'd1;
         by <= bus.y_du ? by + 10'd1 : by - 10'd1;
      end
   end

   assign bus.ball_x = bx;
   assign bus.ball_y = by;

   int cyc = 0;
   int base = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_checks = 0;
   int   n_fail   = 0;
   bit   mon_en   = 0;
   bit   done     = 0;
   exp_t exp_q[$];

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic push(input int kind, input int c, input int x, input int y,
                       input int xdu, input int ydu, input int lv);
      exp_t e;
      e.kind = kind; e.cyc = c; e.x = x; e.y = y; e.xdu = xdu; e.ydu = ydu; e.lives = lv;
      exp_q.push_back(e);
   endtask

   task automatic push_step(input int c, input int x, input int y,
                            input int xdu, input int ydu, input int lv);
      push(KStep, c, x, y, xdu, ydu, lv);
   endtask

   task automatic take(input int kind);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none",
                  kind, cyc - base);
         return;
      end
      e = exp_q.pop_front();
      chk($sformatf("event_kind@%0d", e.cyc), kind, e.kind);
      chk($sformatf("event_cycle@%0d", e.cyc), cyc - base, e.cyc);
      if (kind == KStep && e.kind == KStep) begin
         chk($sformatf("step@%0d x", e.cyc), int'(bx), e.x);
         chk($sformatf("step@%0d y", e.cyc), int'(by), e.y);
         chk($sformatf("step@%0d x_du", e.cyc), int'(bus.x_du), e.xdu);
         chk($sformatf("step@%0d y_du", e.cyc), int'(bus.y_du), e.ydu);
         chk($sformatf("step@%0d lives", e.cyc), int'(bus.lives), e.lives);
      end else if ((kind == KLost || kind == KOver) && kind == e.kind) begin
         chk($sformatf("end@%0d lives", e.cyc), int'(bus.lives), e.lives);
      end
   endtask

   // Monitor: pops one expectation per DUT event, sampled mid-cycle.
   logic lost_prev = 1'b0;
   logic over_prev = 1'b0;
   always @(negedge clk) begin
      if (mon_en && resetn) begin
         if (bus.move_en)                         take(KStep);
         else if (bus.paddle_hit)                 take(KPaddle);
         else if (bus.ball_lost && !lost_prev)    take(KLost);
         else if (bus.game_over && !over_prev)    take(KOver);
      end
      lost_prev <= bus.ball_lost;
      over_prev <= bus.game_over;
   end

   task automatic at(input int r);
      while (cyc < base + r) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load(input int r, input int x, input int y);
      at(r);
      ld = 1'b1; ld_x = 10'(x); ld_y = 10'(y);
      at(r + 1);
      ld = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " move_en"},    int'(bus.move_en), 0);
      chk({tag, " x_du"},       int'(bus.x_du), 1);
      chk({tag, " y_du"},       int'(bus.y_du), 1);
      chk({tag, " pos_clr_n"},  int'(bus.pos_clr_n), 0);
      chk({tag, " paddle_hit"}, int'(bus.paddle_hit), 0);
      chk({tag, " ball_lost"},  int'(bus.ball_lost), 0);
      chk({tag, " game_over"},  int'(bus.game_over), 0);
      chk({tag, " lives"},      int'(bus.lives), 0);
   endtask

   task automatic summary();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
   endtask

   initial begin
      bus.start = 1'b0; bus.pause = 1'b0; bus.hit_x = 1'b0; bus.hit_y = 1'b0;
      bus.paddle_x = 10'd100;
      ld = 1'b0; ld_x = '0; ld_y = '0;

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      resetn = 1'b1;
      @(posedge clk);
      #1;

      // Serve: SERVE at 1, MOVE at 2, first step at 6, next at 12.
      bus.start = 1'b1;
      base = cyc;
      mon_en = 1;
      push_step(6, 0, 0, 1, 1, 2);
      push_step(12, 1, 1, 1, 1, 2);
      at(1);
      bus.start = 1'b0;

      // Right wall at x=316 flips x_du, next step goes back to 315.
      push_step(18, 315, 100, 1, 1, 2);
      push_step(24, 316, 101, 0, 1, 2);
      push_step(30, 315, 102, 0, 1, 2);
      load(14, 315, 100);

      // Paddle bounce at (110,220) with paddle_x=100.
      push_step(36, 111, 219, 0, 1, 2);
      push(KPaddle, 38, 0, 0, 0, 0, 0);
      push_step(42, 110, 220, 0, 0, 2);
      push_step(48, 109, 219, 0, 0, 2);
      load(32, 111, 219);

      // Top wall.
      push_step(54, 50, 1, 0, 0, 2);
      push_step(60, 49, 0, 0, 1, 2);
      push_step(66, 48, 1, 0, 1, 2);
      load(50, 50, 1);

      // Same approach with paddle_x=200: no bounce.
      push_step(72, 111, 219, 0, 1, 2);
      push_step(78, 110, 220, 0, 1, 2);
      push_step(84, 109, 221, 0, 1, 2);
      at(68);
      bus.paddle_x = 10'd200;
      load(68, 111, 219);

      // Brick hit in the same CHECK as the left wall; must not leak into the next CHECK.
      push_step(90, 1, 100, 0, 1, 2);
      push_step(96, 0, 101, 1, 1, 2);
      push_step(102, 1, 102, 1, 1, 2);
      load(86, 1, 100);
      at(91); bus.hit_x = 1'b1;
      at(92); bus.hit_x = 1'b0;

      // Two hit_x pulses in one MOVE give one toggle.
      push_step(108, 2, 103, 0, 1, 2);
      push_step(114, 1, 104, 0, 1, 2);
      at(98);  bus.hit_x = 1'b1;
      at(99);  bus.hit_x = 1'b0;
      at(100); bus.hit_x = 1'b1;
      at(101); bus.hit_x = 1'b0;

      // Single hit_y pulse toggles y_du; left wall restores x_du.
      push_step(120, 0, 105, 1, 0, 2);
      at(110); bus.hit_y = 1'b1;
      at(111); bus.hit_y = 1'b0;

      // Pause for 10 cycles in MOVE delays the step from 126 to 136.
      push_step(136, 1, 104, 1, 0, 2);
      at(122); bus.pause = 1'b1;
      at(132); bus.pause = 1'b0;

      // First loss: turn downward and fall past y=236.
      push_step(142, 50, 235, 1, 0, 2);
      push_step(148, 51, 234, 1, 1, 2);
      push_step(154, 52, 235, 1, 1, 2);
      push(KLost, 156, 0, 0, 0, 0, 1);
      at(138); bus.hit_y = 1'b1; ld = 1'b1; ld_x = 10'd50; ld_y = 10'd235;
      at(139); bus.hit_y = 1'b0; ld = 1'b0;
      at(158);
      chk("ball_lost level", int'(bus.ball_lost), 1);

      // Re-serve keeps lives and restarts from (0,0); second loss ends the game.
      push_step(166, 0, 0, 1, 1, 1);
      push_step(172, 60, 235, 1, 1, 1);
      push(KOver, 174, 0, 0, 0, 0, 0);
      at(160); bus.start = 1'b1;
      at(161); bus.start = 1'b0;
      load(168, 60, 235);
      at(176);
      chk("game_over level", int'(bus.game_over), 1);

      // Start from OVER reloads lives.
      push_step(184, 0, 0, 1, 1, 2);
      at(178); bus.start = 1'b1;
      at(179); bus.start = 1'b0;

      // Asynchronous reset in the middle of a STEP.
      at(190);
      chk("move_en before reset", int'(bus.move_en), 1);
      mon_en = 0;
      resetn = 1'b0;
      #1;
      check_reset_outputs("midstep_reset");
      chk("scoreboard drained", exp_q.size(), 0);

      done = 1;
      summary();
      $finish;
   end

   initial begin
      repeat (1500) @(posedge clk);
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL watchdog: got cycle %0d, required completion", cyc - base);
         summary();
         $finish;
      end
   end

endmodule
